mux_4_1: RTL and testbench

MUX_4_1 -- requirements
Module: mux_4_1

---
 rtl/mux_pkg.sv | 14 +
 rtl/mux_4_1_comb.sv | 35 +++
 rtl/mux_4_1.sv | 84 ++++++++
 tb/tb_mux_4_1.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared select encodings for the 4:1 mux, used by RTL and bench alike.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mux_pkg;

  typedef logic [1:0] sel_t;

  // {s1,s0} encodings naming which data input is steered to y
  localparam sel_t SEL_I0 = 2'b00;
  localparam sel_t SEL_I1 = 2'b01;
  localparam sel_t SEL_I2 = 2'b10;
  localparam sel_t SEL_I3 = 2'b11;

endpackage

// File: rtl/mux_4_1_comb.sv
// Purely combinational WIDTH-wide 4:1 selector.
// Latency: zero (no state).
// Backpressure: none; output follows inputs continuously.
//
// Ports:
//   sel         : {s1,s0} select
//   i0..i3      : WIDTH-bit data inputs
//   y           : selected data, bit-for-bit copy of the chosen input
module mux_4_1_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  sel_t             sel,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      SEL_I0:  y = i0;
      SEL_I1:  y = i1;
      SEL_I2:  y = i2;
      SEL_I3:  y = i3;
      // An X/Z select matches no item, so simulation shows all-X on y;
      // synthesis treats this branch as don't-care.
      default: y = 'x;
    endcase
  end

endmodule

// File: rtl/mux_4_1.sv
// 4:1 data mux with optional output register (REG_OUT) and select echo.
// Latency: 1 cycle when REG_OUT=1 (load gated by en), 0 when REG_OUT=0.
// Backpressure: none; en=0 simply holds the registered result.
//
// Ports:
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   en          : output register load enable (unused when REG_OUT=0)
//   i0..i3      : WIDTH-bit data inputs
//   s0, s1      : select LSB / MSB
//   y           : selected data
//   sel_q       : {s1,s0} that produced the current y
module mux_4_1
  import mux_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] y,
  output logic [1:0]       sel_q
);

  sel_t             sel;
  logic [WIDTH-1:0] mux_dat;

  assign sel = {s1, s0};

  mux_4_1_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .sel (sel),
    .i0  (i0),
    .i1  (i1),
    .i2  (i2),
    .i3  (i3),
    .y   (mux_dat)
  );

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;
    sel_t             sel_reg_d;
    sel_t             sel_reg_q;

    always_comb begin
      y_d       = y_q;
      sel_reg_d = sel_reg_q;
      if (en) begin
        y_d       = mux_dat;
        sel_reg_d = sel;
      end
    end

    // Reset wins over en, so a selection presented during reset is dropped.
    always_ff @(posedge clk) begin
      if (rst) begin
        y_q       <= '0;
        sel_reg_q <= SEL_I0;
      end else begin
        y_q       <= y_d;
        sel_reg_q <= sel_reg_d;
      end
    end

    assign y     = y_q;
    assign sel_q = sel_reg_q;
  end else begin : g_comb
    assign y     = mux_dat;
    assign sel_q = sel;

    // Clock, reset and enable have no role in the combinational build.
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, en};
  end

endmodule

// File: tb/tb_mux_4_1.sv
// Directed self-checking bench for mux_4_1: registered and combinational
// builds at WIDTH=1, registered build at WIDTH=8.
// Inputs are driven and outputs sampled 1 ns after the rising clock edge.
`timescale 1ns/100ps
module tb_mux_4_1;
  import mux_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] i0, i1, i2, i3;
  logic       s0, s1;

  logic       y_r1, y_c1;
  logic [1:0] selq_r1, selq_c1, selq_r8;
  logic [7:0] y_r8;

  int n_cmp;
  int n_err;

  mux_4_1 #(.WIDTH(1), .REG_OUT(1'b1)) u_r1 (
    .clk(clk), .rst(rst), .en(en),
    .i0(i0[0]), .i1(i1[0]), .i2(i2[0]), .i3(i3[0]),
    .s0(s0), .s1(s1), .y(y_r1), .sel_q(selq_r1)
  );

  mux_4_1 #(.WIDTH(1), .REG_OUT(1'b0)) u_c1 (
    .clk(clk), .rst(rst), .en(en),
    .i0(i0[0]), .i1(i1[0]), .i2(i2[0]), .i3(i3[0]),
    .s0(s0), .s1(s1), .y(y_c1), .sel_q(selq_c1)
  );

  mux_4_1 #(.WIDTH(8), .REG_OUT(1'b1)) u_r8 (
    .clk(clk), .rst(rst), .en(en),
    .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .s0(s0), .s1(s1), .y(y_r8), .sel_q(selq_r8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode written out from the select table.
  function automatic logic [7:0] ref_mux(input logic [7:0] a0, input logic [7:0] a1,
                                         input logic [7:0] a2, input logic [7:0] a3,
                                         input logic b1, input logic b0);
    sel_t s;
    s = {b1, b0};
    if (s == SEL_I0)      return a0;
    else if (s == SEL_I1) return a1;
    else if (s == SEL_I2) return a2;
    else                  return a3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic [1:0] s);
    s1 = s[1];
    s0 = s[0];
  endtask

  logic [7:0] exp_y;
  logic [7:0] tbl [4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; en = 1'b0;
    i0 = '0; i1 = '0; i2 = '0; i3 = '0;
    s0 = 1'b0; s1 = 1'b0;

    // Reset for two cycles
    tick();
    tick();
    chk("rst_y_r1",    64'(y_r1),    64'h0);
    chk("rst_selq_r1", 64'(selq_r1), 64'h0);
    chk("rst_y_r8",    64'(y_r8),    64'h0);
    chk("rst_selq_r8", 64'(selq_r8), 64'h0);

    // First load after reset release
    rst = 1'b0; en = 1'b1;
    i0 = 8'h01; i1 = 8'h00; i2 = 8'h00; i3 = 8'h00;
    set_sel(SEL_I0);
    tick();
    chk("first_load_y_r1", 64'(y_r1), 64'h1);

    // Exhaustive WIDTH=1 sweep over {i3,i2,i1,i0,s1,s0}
    for (int v = 0; v < 64; v++) begin
      i0 = {7'b0, v[2]};
      i1 = {7'b0, v[3]};
      i2 = {7'b0, v[4]};
      i3 = {7'b0, v[5]};
      s1 = v[1];
      s0 = v[0];
      exp_y = ref_mux(i0, i1, i2, i3, s1, s0);
      #1;
      chk("sweep_y_c1",    64'(y_c1),    64'(exp_y[0]));
      chk("sweep_selq_c1", 64'(selq_c1), 64'(v[1:0]));
      tick();
      chk("sweep_y_r1",    64'(y_r1),    64'(exp_y[0]));
      chk("sweep_selq_r1", 64'(selq_r1), 64'(v[1:0]));
    end

    // WIDTH=8 select stepping
    i0 = 8'h11; i1 = 8'h22; i2 = 8'h44; i3 = 8'h88;
    tbl[0] = 8'h11; tbl[1] = 8'h22; tbl[2] = 8'h44; tbl[3] = 8'h88;
    for (int k = 0; k < 4; k++) begin
      set_sel(2'(k));
      tick();
      chk("step_y_r8",    64'(y_r8),    64'(tbl[k]));
      chk("step_selq_r8", 64'(selq_r8), 64'(k));
    end

    // en hold: load 44, then freeze while select and data move
    set_sel(SEL_I2);
    tick();
    chk("hold_load_y", 64'(y_r8), 64'h44);
    en = 1'b0;
    set_sel(SEL_I3);
    i2 = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_y",    64'(y_r8),    64'h44);
      chk("hold_selq", 64'(selq_r8), 64'h2);
    end
    en = 1'b1;
    tick();
    chk("unhold_y",    64'(y_r8),    64'h88);
    chk("unhold_selq", 64'(selq_r8), 64'h3);

    // Reset mid-stream beats en; combinational build ignores reset
    i2 = 8'h44;
    rst = 1'b1;
    set_sel(SEL_I3);
    tick();
    chk("midrst_y_r8",    64'(y_r8),    64'h0);
    chk("midrst_selq_r8", 64'(selq_r8), 64'h0);
    chk("midrst_y_r1",    64'(y_r1),    64'h0);
    chk("midrst_y_c1",    64'(y_c1),    64'(i3[0]));
    rst = 1'b0;
    tick();
    chk("postrst_y_r8",    64'(y_r8),    64'h88);
    chk("postrst_selq_r8", 64'(selq_r8), 64'h3);

    // Toggle stress on the combinational build: 1 ns steps over 100 ns
    for (int t = 0; t < 100; t++) begin
      i0 = {7'b0, 1'((t / 40) % 2)};
      i1 = {7'b0, 1'((t / 20) % 2)};
      i2 = {7'b0, 1'((t / 10) % 2)};
      i3 = {7'b0, 1'((t / 5) % 2)};
      s0 = 1'((t / 2) % 2);
      s1 = 1'(t % 2);
      exp_y = ref_mux(i0, i1, i2, i3, s1, s0);
      #0.5;
      chk("stress_y_c1",    64'(y_c1),    64'(exp_y[0]));
      chk("stress_selq_c1", 64'(selq_c1), 64'({s1, s0}));
      #0.5;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
